// File: rtl/scr1_tcm_loader_pkg.sv
// Shared types and constants for the TCM stream loader.
package scr1_tcm_loader_pkg;

  localparam int unsigned CsumWidth = 32;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StVrd,
    StVwait,
    StDone
  } loader_state_e;

endpackage

// File: rtl/scr1_tcm_loader_csum.sv
// Clearable modular accumulator; carry out of the top bit is dropped.
module scr1_tcm_loader_csum
  import scr1_tcm_loader_pkg::*;
#(
  parameter int unsigned Width = CsumWidth
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] val_i,
  output logic [Width-1:0] sum_o,
  output logic [Width-1:0] sum_next_o
);

  logic [Width-1:0] sum_d, sum_q;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (en_i) begin
      sum_d = sum_q + val_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o      = sum_q;
  assign sum_next_o = sum_d;

endmodule

// File: rtl/scr1_tcm_loader.sv
// Streams words into TCM port B; SCR1_TCM_LOADER_VERIFY_EN adds a read-back checksum verify.
module scr1_tcm_loader
  import scr1_tcm_loader_pkg::*;
#(
  parameter int unsigned  SCR1_WIDTH  = 32,
  parameter int unsigned  SCR1_SIZE   = 'h00010000,
  parameter int unsigned  SCR1_NBYTES = SCR1_WIDTH / 8,
  localparam int unsigned AW          = $clog2(SCR1_SIZE) - 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [AW-1:0]          base_addr,
  input  logic [AW:0]            word_cnt,
  input  logic                   s_valid,
  input  logic [SCR1_WIDTH-1:0]  s_data,
  output logic                   s_ready,
  output logic                   wenb,
  output logic [SCR1_NBYTES-1:0] webb,
  output logic [AW-1:0]          addrb,
  output logic [SCR1_WIDTH-1:0]  datab,
  output logic                   renb,
  input  logic [SCR1_WIDTH-1:0]  qb,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  loader_state_e state_d, state_q;
  logic [AW-1:0] addr_d, addr_q;
  logic [AW:0]   remain_d, remain_q;
  logic          rd_en;
  logic          last_beat;

  assign last_beat = (remain_q == (AW+1)'(1));

`ifdef SCR1_TCM_LOADER_VERIFY_EN
  logic [AW-1:0]         base_q;
  logic [AW:0]           cnt_q;
  logic                  rd_pend_q;
  logic                  err_d, err_q;
  logic                  csum_clr;
  logic [SCR1_WIDTH-1:0] wr_sum, wr_sum_next, rd_sum, rd_sum_next;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    s_ready  = 1'b0;
    wenb     = 1'b0;
    rd_en    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (word_cnt == '0) begin
            state_d = StDone;
          end else begin
            addr_d   = base_addr;
            remain_d = word_cnt;
            state_d  = StWrite;
          end
        end
      end
      StWrite: begin
        busy    = 1'b1;
        s_ready = 1'b1;
        if (s_valid) begin
          wenb     = 1'b1;
          addr_d   = addr_q + AW'(1);
          remain_d = remain_q - (AW+1)'(1);
          if (last_beat) begin
`ifdef SCR1_TCM_LOADER_VERIFY_EN
            // Rewind to the first word for the read-back pass.
            addr_d   = base_q;
            remain_d = cnt_q;
            state_d  = StVrd;
`else
            state_d  = StDone;
`endif
          end
        end
      end
      StVrd: begin
        busy     = 1'b1;
        rd_en    = 1'b1;
        addr_d   = addr_q + AW'(1);
        remain_d = remain_q - (AW+1)'(1);
        if (last_beat) begin
          state_d = StVwait;
        end
      end
      StVwait: begin
        busy    = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
    end
  end

  // Port B is held at zero whenever no access is issued.
  assign webb  = {SCR1_NBYTES{wenb}};
  assign addrb = (wenb || rd_en) ? addr_q : '0;
  assign datab = wenb ? s_data : '0;

`ifdef SCR1_TCM_LOADER_VERIFY_EN
  assign csum_clr = (state_q == StIdle) && start && (word_cnt != '0);

  always_comb begin
    err_d = err_q;
    if ((state_q == StIdle) && start) begin
      err_d = 1'b0;
    end else if (state_q == StVwait) begin
      // Compare against the read sum including the final word landing this cycle.
      err_d = (wr_sum_next != rd_sum_next);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q    <= '0;
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (csum_clr) begin
        base_q <= base_addr;
        cnt_q  <= word_cnt;
      end
      rd_pend_q <= rd_en;
      err_q     <= err_d;
    end
  end

  scr1_tcm_loader_csum #(
    .Width (SCR1_WIDTH)
  ) u_wr_csum (
    .clk_i      (clk),
    .rst_ni     (rst),
    .clr_i      (csum_clr),
    .en_i       (wenb),
    .val_i      (s_data),
    .sum_o      (wr_sum),
    .sum_next_o (wr_sum_next)
  );

  scr1_tcm_loader_csum #(
    .Width (SCR1_WIDTH)
  ) u_rd_csum (
    .clk_i      (clk),
    .rst_ni     (rst),
    .clr_i      (csum_clr),
    .en_i       (rd_pend_q),
    .val_i      (qb),
    .sum_o      (rd_sum),
    .sum_next_o (rd_sum_next)
  );

  assign renb = rd_en;
  assign err  = err_q;
`else
  logic [SCR1_WIDTH-1:0] unused_qb;
  assign unused_qb = qb;
  assign renb      = 1'b0;
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_scr1_tcm_loader.sv
// Directed bench for scr1_tcm_loader with a simple port-B memory model.
module tb_scr1_tcm_loader;

  localparam int unsigned AW = 14;
`ifdef SCR1_TCM_LOADER_VERIFY_EN
  localparam bit VerifyEn = 1'b1;
`else
  localparam bit VerifyEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_cnt = '0;
  logic          s_valid = 1'b0;
  logic [31:0]   s_data = '0;
  logic          s_ready, wenb, renb, busy, done, err;
  logic [3:0]    webb;
  logic [AW-1:0] addrb;
  logic [31:0]   datab;
  logic [31:0]   qb = '0;

  logic [31:0]   mem [0:(1<<AW)-1];
  logic          corrupt = 1'b0;

  int total = 0;
  int bad   = 0;

  scr1_tcm_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .word_cnt  (word_cnt),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .wenb      (wenb),
    .webb      (webb),
    .addrb     (addrb),
    .datab     (datab),
    .renb      (renb),
    .qb        (qb),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Memory model; corrupt flips 0x2 to 0x6 when reading word 1.
  always @(posedge clk) begin
    if (wenb) mem[addrb] <= datab;
    if (renb) qb <= mem[addrb] ^ ((corrupt && addrb == AW'(1)) ? 32'h4 : 32'h0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_wenb"}, 32'(wenb), 0);
    check({tag, "_renb"}, 32'(renb), 0);
    check({tag, "_webb"}, 32'(webb), 0);
    check({tag, "_addrb"}, 32'(addrb), 0);
    check({tag, "_datab"}, datab, 0);
    check({tag, "_s_ready"}, 32'(s_ready), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"}, 32'(err), 0);
  endtask

  // Called at a negedge in IDLE; returns at the first negedge after start.
  task automatic start_load(input logic [AW-1:0] b, input logic [AW:0] n);
    start     = 1'b1;
    base_addr = b;
    word_cnt  = n;
    #1;
    check("idle_busy", 32'(busy), 0);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] d, input logic [AW-1:0] exp_addr);
    s_valid = 1'b1;
    s_data  = d;
    #1;
    check("wr_wenb", 32'(wenb), 1);
    check("wr_addrb", 32'(addrb), 32'(exp_addr));
    check("wr_datab", datab, d);
    check("wr_webb", 32'(webb), 32'hf);
    check("wr_s_ready", 32'(s_ready), 1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic finish_load(input int n, input logic [AW-1:0] b, input logic exp_err);
    int steps = 0;
    int reads = 0;
    bit seen = 1'b0;
    logic [AW-1:0] ea;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (renb) begin
        ea = b + AW'(reads);
        check("vrd_addr", 32'(addrb), 32'(ea));
        reads++;
      end
      if (wenb) check("stray_wenb", 32'(wenb), 0);
      if (done) seen = 1'b1;
      else begin
        steps++;
        @(negedge clk);
      end
    end
    check("done_seen", 32'(seen), 1);
    check("done_latency", 32'(steps), VerifyEn ? 32'(n + 1) : 0);
    check("read_count", 32'(reads), VerifyEn ? 32'(n) : 0);
    check("done_err", 32'(err), 32'(exp_err));
    @(negedge clk);
    check("done_pulse", 32'(done), 0);
    check("post_busy", 32'(busy), 0);
  endtask

  initial begin
    // Reset with junk on the inputs.
    start   = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'hdead_beef;
    word_cnt = 15'd3;
    repeat (3) @(negedge clk);
    check_quiet("rst");
    rst     = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);

    // Basic 3-word load at 0.
    start_load(14'd0, 15'd3);
    do_write(32'd1, 14'd0);
    do_write(32'd2, 14'd1);
    do_write(32'd3, 14'd2);
    finish_load(3, 14'd0, 1'b0);

    // Address wrap from the top word.
    start_load(14'h3fff, 15'd2);
    do_write(32'd10, 14'h3fff);
    do_write(32'd20, 14'd0);
    finish_load(2, 14'h3fff, 1'b0);

    // Zero-length load: done next cycle, no access, stream not consumed.
    start     = 1'b1;
    word_cnt  = '0;
    s_valid   = 1'b1;
    s_data    = 32'h55;
    #1;
    check("z_s_ready", 32'(s_ready), 0);
    @(negedge clk);
    start = 1'b0;
    check("z_done", 32'(done), 1);
    check("z_wenb", 32'(wenb), 0);
    check("z_busy", 32'(busy), 0);
    check("z_s_ready2", 32'(s_ready), 0);
    @(negedge clk);
    check("z_done_pulse", 32'(done), 0);
    check("z_wenb2", 32'(wenb), 0);
    s_valid = 1'b0;

    // Gapped stream: address advances only on transfers.
    start_load(14'd5, 15'd2);
    do_write(32'haaaa, 14'd5);
    #1;
    check("gap_wenb", 32'(wenb), 0);
    check("gap_s_ready", 32'(s_ready), 1);
    check("gap_busy", 32'(busy), 1);
    @(negedge clk);
    do_write(32'hbbbb, 14'd6);
    finish_load(2, 14'd5, 1'b0);

    // Corrupted read-back flags err; next start clears it.
    corrupt = 1'b1;
    start_load(14'd0, 15'd3);
    do_write(32'd1, 14'd0);
    do_write(32'd2, 14'd1);
    do_write(32'd3, 14'd2);
    finish_load(3, 14'd0, VerifyEn);
    corrupt = 1'b0;
    start_load(14'd0, 15'd1);
    check("err_cleared", 32'(err), 0);
    do_write(32'd5, 14'd0);
    finish_load(1, 14'd0, 1'b0);

    // Reset mid-load aborts; a new start reloads from base_addr.
    start_load(14'd7, 15'd4);
    do_write(32'd11, 14'd7);
    s_valid = 1'b1;
    s_data  = 32'd12;
    rst     = 1'b0;
    #1;
    check_quiet("abort");
    @(negedge clk);
    check_quiet("abort_hold");
    rst = 1'b1;
    #1;
    check("post_rst_wenb", 32'(wenb), 0);
    check("post_rst_s_ready", 32'(s_ready), 0);
    @(negedge clk);
    check("post_rst_wenb2", 32'(wenb), 0);
    check("post_rst_busy", 32'(busy), 0);
    s_valid = 1'b0;
    start_load(14'd7, 15'd2);
    do_write(32'd21, 14'd7);
    do_write(32'd22, 14'd8);
    finish_load(2, 14'd7, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scr1_tcm_loader.md
SCR1_TCM_LOADER -- requirements
Module: scr1_tcm_loader

Interface
REQ-001 SHALL have parameter SCR1_WIDTH, default 32, memory word width in bits.
REQ-002 SHALL have parameter SCR1_SIZE, default 'h00010000, memory size in bytes; AW = $clog2(SCR1_SIZE)-2.
REQ-003 SHALL have parameter SCR1_NBYTES, default SCR1_WIDTH/8, byte lanes per word.
REQ-004 SHALL have one clock and an asynchronous, active-low reset:
- clk  in  1  rising-edge clock for all state.
- rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have the control ports:
- start  in  1  one-cycle request to begin a load, sampled only in IDLE.
- base_addr  in  AW  first word address, captured on start.
- word_cnt  in  AW+1  number of words to load, captured on start.
REQ-006 SHALL have the stream input ports:
- s_valid  in  1  stream word valid.
- s_data  in  SCR1_WIDTH  stream word.
- s_ready  out  1  loader accepts s_data this cycle.
REQ-007 SHALL have the memory port-B initiator ports:
- wenb  out  1  write enable.
- webb  out  SCR1_NBYTES  byte enables.
- addrb  out  AW  word address.
- datab  out  SCR1_WIDTH  write data.
- renb  out  1  read enable.
- qb  in  SCR1_WIDTH  read data, valid one cycle after renb.
REQ-008 SHALL have the status ports:
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse at load completion.
- err  out  1  verify mismatch, held until the next accepted start.

Function
REQ-009 SHALL implement the states IDLE, WRITE, VRD (verify read), VWAIT (last read data pending), and DONE.
REQ-010 IDLE SHALL go to DONE when start=1 and word_cnt=0, without issuing any memory access.
REQ-011 IDLE SHALL go to WRITE when start=1 and word_cnt!=0, capturing base_addr and word_cnt and clearing err and the checksum.
REQ-012 In WRITE, s_ready SHALL be 1, and a transfer SHALL occur on each cycle with s_valid=1.
REQ-013 On each WRITE transfer, wenb=1, webb=all ones, addrb=current address and datab=s_data SHALL be driven combinationally in the same cycle.
REQ-014 On each WRITE transfer, the address SHALL increment modulo 2^AW and the remaining count SHALL decrement.
REQ-015 On each WRITE transfer, s_data SHALL be added to a SCR1_WIDTH-bit checksum, with the carry discarded.
REQ-016 When the transfer that makes the remaining count 0 occurs, WRITE SHALL go to VRD if verify is compiled in, else to DONE.
REQ-017 VRD SHALL issue renb=1 every cycle at consecutive addresses starting at base_addr, with wrap-around, and wenb=0.
REQ-018 VRD SHALL go to VWAIT after the word_cnt-th read.
REQ-019 Read data SHALL be accumulated into a second checksum in the cycle after each renb.
REQ-020 VWAIT SHALL last one cycle, then go to DONE.
REQ-021 On entry to DONE, err SHALL be set if the two checksums differ.
REQ-022 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-023 busy SHALL be 1 in WRITE, VRD and VWAIT.
REQ-024 wenb, renb and s_ready SHALL be 0 outside WRITE and VRD as specified above.
REQ-025 start outside IDLE SHALL be ignored.
REQ-026 s_valid outside WRITE SHALL be ignored and SHALL not be consumed.
REQ-027 word_cnt = 2^AW SHALL load the full memory, wrapping exactly once.

Reset
REQ-028 While rst=0, the state SHALL be IDLE and every output and internal register SHALL be 0: wenb, renb, webb, addrb, datab, s_ready, busy, done, err and the checksums.
REQ-029 Reset asserted mid-load SHALL abort the load immediately with no further memory access, and the loader SHALL require a new start.

Configuration
REQ-030 With SCR1_TCM_LOADER_VERIFY_EN defined, the VRD/VWAIT read-back checksum verify SHALL be present.
REQ-031 Without SCR1_TCM_LOADER_VERIFY_EN, WRITE SHALL go directly to DONE, renb SHALL be tied to 0, err SHALL be tied to 0, and no checksum logic SHALL remain.

Structure
REQ-032 Package scr1_tcm_loader_pkg SHALL hold the state enum typedef and the checksum-width constant.
REQ-033 Sub-module scr1_tcm_loader_csum, a clearable modular accumulator, SHALL be instantiated twice: once for the write checksum and once for the read checksum.

Verification
REQ-034 The bench SHALL cover:
- start, base_addr=0, word_cnt=3, data 1,2,3 with continuous s_valid -> writes at addresses 0,1,2 on 3 consecutive cycles; done pulses; err=0.
- base_addr=2^AW-1, word_cnt=2 -> writes at addresses 2^AW-1 then 0.
- word_cnt=0 -> done the cycle after start; wenb never asserted.
- s_valid toggling 1,0,1,0 for 2 words -> exactly 2 writes; address advances only on transfers.
- Verify on, bench memory model corrupts word 1 (0x2 to 0x6) -> err=1 at done; err cleared by the next start.
- Reset asserted during WRITE after 1 of 4 words -> all outputs 0 next edge; a later start reloads from base_addr.
